// File: rtl/output_transform_unit.sv
// output_transform_unit: Winograd F(4x4,3x3) output transform Y = sat(A^T * M * A)
//   clk            : rising-edge clock
//   rst            : asynchronous active-high reset
//   start          : request one transform (accepted in IDLE only)
//   m_in           : signed 6x6 Winograd-domain product tile
//   y_out          : signed 4x4 registered, saturated spatial result
//   transform_done : one-cycle completion pulse
//   busy           : high while not IDLE
//   overflow       : high if any element of the last result saturated
module output_transform_unit #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] m_in [0:5][0:5],
  output logic signed [DATA_W-1:0] y_out [0:3][0:3],
  output logic                     transform_done,
  output logic                     busy,
  output logic                     overflow
);
  // T rows grow by at most 19x and Y by 19x19, so these widths never wrap
  localparam int TW = DATA_W + 5;
  localparam int YW = DATA_W + 10;
  localparam logic signed [YW-1:0] YMAX = {{(YW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [YW-1:0] YMIN = {{(YW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC_T, CALC_Y, DONE} state_t;
  state_t state_q, state_d;
  logic signed [DATA_W-1:0] m_q [0:5][0:5];
  logic signed [TW-1:0] t_q [0:3][0:5];
  logic signed [TW-1:0] t_d [0:3][0:5];
  logic signed [YW-1:0] ysum [0:3][0:3];
  logic signed [DATA_W-1:0] y_d [0:3][0:3];
  logic ovf_d;
  // One A^T row applied to a 6-vector, shift-and-add only
  function automatic logic signed [YW-1:0] xf(input logic [1:0] r,
    input logic signed [YW-1:0] v0, v1, v2, v3, v4, v5);
    return r == 2'd0 ? v0 + v1 + v2 + v3 + v4 :
           r == 2'd1 ? v1 - v2 + ((v3 - v4) <<< 1) :
           r == 2'd2 ? v1 + v2 + ((v3 + v4) <<< 2) :
                       v1 - v2 + ((v3 - v4) <<< 3) + v5;
  endfunction
  always_comb begin
    state_d = state_q == IDLE   ? (start ? CALC_T : IDLE) :
              state_q == CALC_T ? CALC_Y :
              state_q == CALC_Y ? DONE : IDLE;
    ovf_d = 1'b0;
    for (int j = 0; j < 6; j++)
      for (int i = 0; i < 4; i++)
        t_d[i][j] = TW'(xf(2'(i), YW'(m_q[0][j]), YW'(m_q[1][j]), YW'(m_q[2][j]),
                           YW'(m_q[3][j]), YW'(m_q[4][j]), YW'(m_q[5][j])));
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ysum[i][k] = xf(2'(k), YW'(t_q[i][0]), YW'(t_q[i][1]), YW'(t_q[i][2]),
                        YW'(t_q[i][3]), YW'(t_q[i][4]), YW'(t_q[i][5]));
        y_d[i][k] = ysum[i][k] > YMAX ? YMAX[DATA_W-1:0] :
                    ysum[i][k] < YMIN ? YMIN[DATA_W-1:0] : ysum[i][k][DATA_W-1:0];
        ovf_d = ovf_d | (ysum[i][k] > YMAX) | (ysum[i][k] < YMIN);
      end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      transform_done <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          m_q[i][j] <= '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 6; j++)
          t_q[i][j] <= '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          y_out[i][j] <= '0;
    end else begin
      state_q <= state_d;
      transform_done <= state_q == DONE;
      if (state_q == IDLE && start) m_q <= m_in;
      if (state_q == CALC_T) t_q <= t_d;
      if (state_q == CALC_Y) begin
        y_out <= y_d;
        overflow <= ovf_d;
      end
    end
  end
  assign busy = state_q != IDLE;
endmodule

// File: doc/output_transform_unit.md
OUTPUT_TRANSFORM_UNIT -- requirements
Module: output_transform_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, signed width of every m_in and y_out element.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request one transform; honoured only in IDLE.
REQ-005 SHALL have port m_in[0:5][0:5], input, DATA_W each: signed 6x6 Winograd-domain product tile M (U' elementwise V).
REQ-006 SHALL have port y_out[0:3][0:3], output, DATA_W each: signed 4x4 spatial result Y = A^T*M*A, registered.
REQ-007 SHALL have port transform_done, output, 1 bit: registered one-cycle completion pulse.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port overflow, output, 1 bit: registered; high if any y_out element of the last transform saturated.

Function
REQ-010 SHALL use A^T rows: r0=[1 1 1 1 1 0], r1=[0 1 -1 2 -2 0], r2=[0 1 1 4 4 0], r3=[0 1 -1 8 -8 1].
REQ-011 SHALL implement all multiplications by shift-and-add only; no multiplier inference.
REQ-012 SHALL implement FSM states IDLE, CALC_T, CALC_Y, DONE; any illegal encoding returns to IDLE.
REQ-013 SHALL, at the edge where state=IDLE and start=1, capture m_in into internal register M_r and move to CALC_T; start is ignored in every other state.
REQ-014 SHALL, in CALC_T, register T = A^T*M_r (4x6) and move to CALC_Y: T[0][j]=m0+m1+m2+m3+m4, T[1][j]=m1-m2+2m3-2m4, T[2][j]=m1+m2+4m3+4m4, T[3][j]=m1-m2+8m3-8m4+m5 (mk = M_r[k][j]).
REQ-015 SHALL, in CALC_Y, register y_out = sat(T*A) using the same four row patterns along each T row, and move to DONE.
REQ-016 SHALL hold T with at least DATA_W+5 bits and the Y sum with at least DATA_W+10 bits, fully sign-extended, so no intermediate wraps.
REQ-017 SHALL saturate each Y element to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; overflow is set in CALC_Y if any element saturated, else cleared.
REQ-018 SHALL, in DONE, set transform_done=1 and move to IDLE; transform_done is cleared at the following edge (exactly one cycle high).
REQ-019 SHALL give fixed latency: start sampled at edge k -> y_out valid after edge k+2 -> transform_done high between edges k+3 and k+4.
REQ-020 SHALL hold y_out and overflow stable from CALC_Y until the next transform's CALC_Y.
REQ-021 SHALL accept a new start in the cycle transform_done is high (state is IDLE), giving back-to-back throughput of one tile per 4 cycles.
REQ-022 SHALL produce results unscaled; normalisation of the 24x kernel-transform scaling (576 total) is done downstream.

Reset
REQ-023 SHALL, while rst=1, immediately force state=IDLE, M_r, T and y_out to all zeros, transform_done=0, overflow=0, busy=0.
REQ-024 SHALL, on rst asserted mid-transform, abandon it with no transform_done pulse; after release, require a fresh start.

Verification
REQ-025 Reset: assert rst during CALC_T -> all outputs 0 within the same cycle; no done pulse after release until a new start.
REQ-026 All-ones M -> rows Y0=[25 0 50 5], Y1=[0 0 0 0], Y2=[50 0 100 10], Y3=[5 0 10 1]; overflow=0; done 4 edges after start.
REQ-027 Impulses: M[0][0]=1 only -> Y[0][0]=1, rest 0; M[5][5]=1 only -> Y[3][3]=1, rest 0; M[3][3]=-1 only -> Y[i][k] = -(r_i[3]*r_k[3]), e.g. Y[3][3]=-64.
REQ-028 Saturation: all M=0x7FFFFFFF -> Y[2][2]=0x7FFFFFFF, Y[0][1]=0, overflow=1; next all-zero tile -> overflow=0.
REQ-029 Handshake: start held high through CALC_T/CALC_Y/DONE -> exactly one transform per 4 cycles, m_in changes after capture do not affect y_out, busy matches state.
REQ-030 Random: 1000 random tiles with random start gaps, including 0 -> y_out matches a bit-exact saturating A^T*M*A reference model.
